// File: rtl/ray_pkg.sv
// Shared types and constants for primary-ray generation: direction width,
// saturation limits, image defaults and the ray_gen FSM encoding.
package ray_pkg;

    localparam int unsigned DIR_W   = 16;
    localparam int unsigned SCALE_W = 16;
    localparam int unsigned COORD_W = 8;
    localparam int unsigned OFFS_W  = COORD_W + 1;
    localparam int unsigned IMG_W   = 256;
    localparam int unsigned IMG_H   = 256;

    typedef logic signed [DIR_W-1:0]  dir_t;
    typedef logic signed [OFFS_W-1:0] offs_t;

    localparam dir_t DIR_MAX = {1'b0, {(DIR_W-1){1'b1}}};
    localparam dir_t DIR_MIN = {1'b1, {(DIR_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OFFS = 2'd1,
        MUL  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/sat_mul.sv
// Signed centred-coordinate times per-pixel scale, arithmetic shift, then
// clamp into the signed direction range.
module sat_mul
    import ray_pkg::*;
#(
    parameter int unsigned FRAC_SHIFT = 8
) (
    input  logic signed [OFFS_W-1:0]  c,
    input  logic signed [SCALE_W-1:0] scale,
    output logic signed [DIR_W-1:0]   d_c
);

    localparam int unsigned PROD_W = OFFS_W + SCALE_W;
    localparam logic signed [PROD_W-1:0] P_MAX = PROD_W'(DIR_MAX);
    localparam logic signed [PROD_W-1:0] P_MIN = PROD_W'(DIR_MIN);

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    assign prod    = PROD_W'(c) * PROD_W'(scale);
    assign shifted = prod >>> FRAC_SHIFT;

    always_comb begin
        d_c = DIR_W'(shifted);
        if (shifted > P_MAX) begin
            d_c = DIR_MAX;
        end else if (shifted < P_MIN) begin
            d_c = DIR_MIN;
        end
    end

endmodule

// File: rtl/ray_gen.sv
// Converts each pixel pulse {y,x} into a camera-space primary ray direction,
// held in a valid/ready register; busy throttles the upstream pixel sequencer.
module ray_gen #(
    parameter int unsigned                        IMG_W      = ray_pkg::IMG_W,
    parameter int unsigned                        IMG_H      = ray_pkg::IMG_H,
    parameter int unsigned                        DIR_W      = ray_pkg::DIR_W,
    parameter logic signed [ray_pkg::SCALE_W-1:0] PIX_SCALE  = 16'sd256,
    parameter logic signed [DIR_W-1:0]            FOCAL      = {1'b1, {(DIR_W-1){1'b0}}},
    parameter int unsigned                        FRAC_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             signal,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    output logic             busy,
    output logic             ray_valid,
    input  logic             ray_ready,
    output logic [DIR_W-1:0] ray_dx,
    output logic [DIR_W-1:0] ray_dy,
    output logic [DIR_W-1:0] ray_dz,
    output logic [7:0]       ray_px,
    output logic [7:0]       ray_py,
    output logic             ray_last,
    output logic             err
);

    import ray_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic               load_pix;
    logic               load_offs;
    logic               load_ray;
    logic               take;
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;
    offs_t              cx_q;
    offs_t              cy_q;
    dir_t               dx_c;
    dir_t               dy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_pix  = 1'b0;
        load_offs = 1'b0;
        load_ray  = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (signal) begin
                    load_pix  = 1'b1;
                    state_nxt = OFFS;
                end
            end
            OFFS: begin
                load_offs = 1'b1;
                state_nxt = MUL;
            end
            MUL: begin
                load_ray  = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                if (ray_ready) begin
                    take      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel latch and centring about the image midpoint (+y is up).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= '0;
            py_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            if (load_pix) begin
                px_q <= x;
                py_q <= y;
            end
            if (load_offs) begin
                cx_q <= offs_t'({1'b0, px_q} - OFFS_W'(IMG_W / 2));
                cy_q <= offs_t'(OFFS_W'(IMG_H / 2) - {1'b0, py_q});
            end
        end
    end

    sat_mul #(.FRAC_SHIFT(FRAC_SHIFT)) u_mul_x (
        .c     (cx_q),
        .scale (PIX_SCALE),
        .d_c   (dx_c)
    );

    sat_mul #(.FRAC_SHIFT(FRAC_SHIFT)) u_mul_y (
        .c     (cy_q),
        .scale (PIX_SCALE),
        .d_c   (dy_c)
    );

    // Output ray register; a pulse outside IDLE is dropped and flagged sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            ray_valid <= 1'b0;
            ray_dx    <= '0;
            ray_dy    <= '0;
            ray_dz    <= '0;
            ray_px    <= '0;
            ray_py    <= '0;
            ray_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (load_pix) begin
                busy <= 1'b1;
            end else if (take) begin
                busy <= 1'b0;
            end
            if (load_ray) begin
                ray_valid <= 1'b1;
                ray_dx    <= DIR_W'(dx_c);
                ray_dy    <= DIR_W'(dy_c);
                ray_dz    <= FOCAL;
                ray_px    <= px_q;
                ray_py    <= py_q;
                ray_last  <= &{py_q, px_q};
            end else if (take) begin
                ray_valid <= 1'b0;
            end
            if (signal && (state != IDLE)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
